// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues word reads to instruction memory and keeps the
// returned instructions in an in-order queue; redirects flush it and drop stale data.
module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INSN_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h80020000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic [ADDR_W-1:0]        req_addr,
    output logic                     req_rw,
    output logic [1:0]               req_size,
    input  logic                     rsp_valid,
    input  logic [INSN_W-1:0]        rsp_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSN_W-1:0]        out_insn,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [INSN_W-1:0] insn_q [DEPTH];
    logic [DEPTH-1:0]  filled;
    logic [PW-1:0]     head;
    logic [PW-1:0]     fill;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [CW-1:0]     pend;
    logic [CW-1:0]     drop;

    logic              req_fire;
    logic              out_fire;
    logic              rsp_drop;
    logic              rsp_fill;
    logic [CW-1:0]     drop_redir;

    always_comb begin
        req_valid  = (count + drop) < CW'(DEPTH);
        req_fire   = req_valid && req_ready;
        out_valid  = filled[head];
        out_fire   = out_valid && out_ready;
        rsp_drop   = rsp_valid && (drop != '0);
        // A response with nothing owed and nothing unfilled is ignored.
        rsp_fill   = rsp_valid && (drop == '0) && (pend != '0);
        // Everything still owed after this cycle becomes stale on a redirect.
        drop_redir = drop - CW'(rsp_drop) + pend - CW'(rsp_fill) + CW'(req_fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            fill     <= '0;
            tail     <= '0;
            count    <= '0;
            pend     <= '0;
            drop     <= '0;
            filled   <= '0;
        end else begin
            if (out_fire) begin
                filled[head] <= 1'b0;
                head         <= head + PW'(1);
            end
            if (rsp_fill) begin
                filled[fill] <= 1'b1;
                fill         <= fill + PW'(1);
            end
            if (redirect) begin
                filled   <= '0;
                head     <= '0;
                fill     <= '0;
                tail     <= '0;
                count    <= '0;
                pend     <= '0;
                drop     <= drop_redir;
                fetch_pc <= redirect_pc & ~ADDR_W'(3);
            end else begin
                if (req_fire) begin
                    tail     <= tail + PW'(1);
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                count <= count + CW'(req_fire) - CW'(out_fire);
                pend  <= pend + CW'(req_fire) - CW'(rsp_fill);
                drop  <= drop - CW'(rsp_drop);
            end
        end
    end

    // Queue payload carries no reset; the filled bits qualify it.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_q[tail] <= fetch_pc;
        end
        if (rsp_fill) begin
            insn_q[fill] <= rsp_data;
        end
    end

    assign req_addr  = fetch_pc;
    assign req_rw    = 1'b0;
    assign req_size  = 2'b00;
    assign out_insn  = insn_q[head];
    assign out_pc    = pc_q[head];
    assign occupancy = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: hand vectors, corner sequences and random traffic
// against a queue-level reference model and a latency-driven memory model.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h80020000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          req_valid;
    logic          req_ready = 1'b0;
    logic [31:0]   req_addr;
    logic          req_rw;
    logic [1:0]    req_size;
    logic          rsp_valid = 1'b0;
    logic [31:0]   rsp_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_insn;
    logic [31:0]   out_pc;
    logic [CW-1:0] occupancy;

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_W(32), .INSN_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rw(req_rw), .req_size(req_size), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
        .out_pc(out_pc), .occupancy(occupancy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // memory model: accepted reads answered in order, no earlier than lat cycles later
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int    lat = 1;
    bit    spur_en = 1'b0;
    bit    rsp_real = 1'b0;

    // reference model: the queue as a list of {pc, insn, filled}
    typedef struct { logic [31:0] pc; logic [31:0] insn; bit filled; } ent_t;
    ent_t        q[$];
    logic [31:0] m_pc = RESET_PC;
    int          m_drop = 0;

    typedef struct {
        bit rr; bit orr; bit redir; logic [31:0] rpc;
        bit e_rv; logic [31:0] e_addr; bit e_ov; logic [31:0] e_pc; int e_occ;
    } vec_t;
    vec_t tbl[19];
    vec_t dummy;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic vec_t mk(input bit rr, input bit orr, input bit redir, input logic [31:0] rpc,
                                input bit rv, input logic [31:0] a, input bit ov,
                                input logic [31:0] pc, input int occ);
        vec_t v;
        v.rr = rr; v.orr = orr; v.redir = redir; v.rpc = rpc;
        v.e_rv = rv; v.e_addr = a; v.e_ov = ov; v.e_pc = pc; v.e_occ = occ;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_in(input bit rr, input bit orr, input bit redir, input logic [31:0] rpc);
        req_ready   = rr;
        out_ready   = orr;
        redirect    = redir;
        redirect_pc = rpc;
    endtask

    task automatic drive_rsp();
        rsp_real = (mq.size() > 0) && (mq[0].due <= cyc);
        if (rsp_real) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(mq[0].addr);
        end else if (spur_en && mq.size() == 0 && $urandom_range(0, 7) == 0) begin
            rsp_valid = 1'b1;
            rsp_data  = $urandom;
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
        end
    endtask

    // One clock cycle: compare outputs mid-cycle, then advance both models.
    task automatic step(input bit use_t, input vec_t v);
        bit   exp_rv;
        bit   exp_ov;
        bit   rf;
        bit   of;
        int   idx;
        int   ui;
        ent_t e;
        @(negedge clk);
        exp_rv = (q.size() + m_drop) < DEPTH;
        exp_ov = (q.size() > 0) && q[0].filled;
        chk("req_valid", req_valid, exp_rv);
        chk("req_addr", req_addr, m_pc);
        chk("req_rw", req_rw, 0);
        chk("req_size", req_size, 0);
        chk("occupancy", occupancy, q.size());
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_insn", out_insn, q[0].insn);
        end
        if (use_t) begin
            chk("tbl_req_valid", req_valid, v.e_rv);
            chk("tbl_req_addr", req_addr, v.e_addr);
            chk("tbl_out_valid", out_valid, v.e_ov);
            if (v.e_ov) begin
                chk("tbl_out_pc", out_pc, v.e_pc);
                chk("tbl_out_insn", out_insn, mem_word(v.e_pc));
            end
            chk("tbl_occupancy", occupancy, v.e_occ);
        end
        rf = exp_rv && req_ready;
        of = exp_ov && out_ready;
        if (rsp_real) mq.delete(0);
        if (rf) mq.push_back('{m_pc, cyc + lat});
        if (of) q.delete(0);
        if (rsp_valid) begin
            if (m_drop > 0) begin
                m_drop--;
            end else begin
                idx = -1;
                foreach (q[i]) if (!q[i].filled && idx < 0) idx = i;
                if (idx >= 0) begin
                    e = q[idx];
                    e.insn = rsp_data;
                    e.filled = 1'b1;
                    q[idx] = e;
                end
            end
        end
        if (redirect) begin
            ui = 0;
            foreach (q[i]) if (!q[i].filled) ui++;
            m_drop = m_drop + ui + (rf ? 1 : 0);
            q.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (rf) begin
            q.push_back('{m_pc, 32'h0, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_rsp();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 32'h0);
        rsp_valid = 1'b0;
        rsp_real  = 1'b0;
        mq.delete();
        q.delete();
        m_drop = 0;
        m_pc   = RESET_PC;
        @(negedge clk);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_addr", req_addr, RESET_PC);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        drive_rsp();
    endtask

    task automatic wait_out(input logic [31:0] exp_pc, input string name);
        for (int k = 0; k < 30 && !out_valid; k++) step(0, dummy);
        if (out_valid) begin
            chk(name, out_pc, exp_pc);
        end else begin
            total++;
            bad++;
            $display("FAIL %s: out_valid never rose, expected pc %0h", name, exp_pc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        dummy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = mk(1, 0, 0, 32'h0,        1, 32'h80020000, 0, 32'h0,        0);
        tbl[1]  = mk(1, 0, 0, 32'h0,        1, 32'h80020004, 0, 32'h0,        1);
        tbl[2]  = mk(1, 0, 0, 32'h0,        1, 32'h80020008, 1, 32'h80020000, 2);
        tbl[3]  = mk(1, 0, 0, 32'h0,        1, 32'h8002000C, 1, 32'h80020000, 3);
        tbl[4]  = mk(1, 0, 0, 32'h0,        0, 32'h80020010, 1, 32'h80020000, 4);
        tbl[5]  = mk(1, 1, 0, 32'h0,        0, 32'h80020010, 1, 32'h80020000, 4);
        tbl[6]  = mk(1, 1, 0, 32'h0,        1, 32'h80020010, 1, 32'h80020004, 3);
        tbl[7]  = mk(1, 1, 0, 32'h0,        1, 32'h80020014, 1, 32'h80020008, 3);
        tbl[8]  = mk(1, 1, 0, 32'h0,        1, 32'h80020018, 1, 32'h8002000C, 3);
        for (int i = 9; i < 14; i++)
            tbl[i] = mk(0, 0, 0, 32'h0,     1, 32'h8002001C, 1, 32'h80020010, 3);
        tbl[14] = mk(1, 1, 1, 32'h80030002, 1, 32'h8002001C, 1, 32'h80020010, 3);
        tbl[15] = mk(1, 1, 0, 32'h0,        1, 32'h80030000, 0, 32'h0,        0);
        tbl[16] = mk(1, 1, 0, 32'h0,        1, 32'h80030004, 0, 32'h0,        1);
        tbl[17] = mk(1, 1, 0, 32'h0,        1, 32'h80030008, 1, 32'h80030000, 2);
        tbl[18] = mk(1, 1, 0, 32'h0,        1, 32'h8003000C, 1, 32'h80030004, 2);

        // startup, fill to full, drain, request stall, redirect
        do_reset();
        lat = 1;
        for (int i = 0; i < 19; i++) begin
            set_in(tbl[i].rr, tbl[i].orr, tbl[i].redir, tbl[i].rpc);
            step(1, tbl[i]);
        end

        // L=3, redirect while three reads are owed
        do_reset();
        lat = 3;
        set_in(1, 1, 0, 32'h0);
        step(0, dummy);
        step(0, dummy);
        set_in(1, 1, 1, 32'h80030000);
        step(0, dummy);
        set_in(1, 1, 0, 32'h0);
        chk("s1_req_valid", req_valid, 1);
        chk("s1_req_addr", req_addr, 32'h80030000);
        wait_out(32'h80030000, "s1_first_pc");

        // redirect coinciding with response, request and output handshakes
        do_reset();
        lat = 2;
        set_in(1, 1, 0, 32'h0);
        repeat (5) step(0, dummy);
        chk("s2_pre_out_valid", out_valid, 1);
        chk("s2_pre_req_valid", req_valid, 1);
        chk("s2_pre_occupancy", occupancy, 3);
        set_in(1, 1, 1, 32'h80040000);
        step(0, dummy);
        set_in(1, 1, 0, 32'h0);
        chk("s2_req_addr", req_addr, 32'h80040000);
        chk("s2_occupancy", occupancy, 0);
        wait_out(32'h80040000, "s2_first_pc");

        // address wrap
        do_reset();
        lat = 1;
        set_in(1, 1, 1, 32'hFFFFFFFC);
        step(0, dummy);
        set_in(1, 1, 0, 32'h0);
        chk("s3_req_addr", req_addr, 32'hFFFFFFFC);
        step(0, dummy);
        chk("s3_req_addr_wrap", req_addr, 32'h00000000);
        wait_out(32'hFFFFFFFC, "s3_first_pc");
        step(0, dummy);
        chk("s3_wrap_out_valid", out_valid, 1);
        chk("s3_wrap_out_pc", out_pc, 32'h00000000);

        // random traffic with variable latency and stray responses
        do_reset();
        spur_en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            lat = $urandom_range(1, 4);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 15) == 0, $urandom);
            step(0, dummy);
        end
        spur_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
